// File: rtl/aes_core.sv
// Iterative AES-128 encryption core: one round per clock and on-the-fly key expansion.
// Ciphertext is available 10 clocks after the start edge, together with a one-cycle done pulse.
module aes_core (
   input  logic         iClk,
   input  logic         iRsn,
   input  logic         iStAes,
   input  logic [127:0] iAesKey,
   input  logic [127:0] iPlainText,
   output logic         oAesDone,
   output logic [127:0] oCpText
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Byte a of the table sits at bits [8*(255-a) +: 8], so the first listed byte is S(0x00).
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[{~a, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Rcon for the key expansion step that produces round key n.
   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [1:0]   r_fsm;
   logic [3:0]   r_cnt;
   logic [127:0] r_state;
   logic [127:0] r_key;
   logic         r_done;
   logic [127:0] r_ct;

   logic [127:0] w_sb;
   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [127:0] w_rk;
   logic [127:0] w_rnd;
   logic [127:0] w_fin;
   logic [31:0]  w_kw3;
   logic [31:0]  w_ktmp;
   logic [31:0]  w_n0, w_n1, w_n2, w_n3;

   always_comb begin
      w_sb = '0;
      for (int n = 0; n < 16; n++) begin
         w_sb[127-8*n -: 8] = sbox(r_state[127-8*n -: 8]);
      end
   end

   // Row r of column c takes the byte from column (c+r) mod 4.
   always_comb begin
      w_sr = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
   end

   always_comb begin
      w_mc = '0;
      for (int c = 0; c < 4; c++) begin
         w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
      end
   end

   assign w_kw3  = r_key[31:0];
   assign w_ktmp = {sbox(w_kw3[23:16]), sbox(w_kw3[15:8]), sbox(w_kw3[7:0]), sbox(w_kw3[31:24])}
                   ^ {rcon(r_cnt), 24'h000000};
   assign w_n0   = r_key[127:96] ^ w_ktmp;
   assign w_n1   = r_key[95:64]  ^ w_n0;
   assign w_n2   = r_key[63:32]  ^ w_n1;
   assign w_n3   = r_key[31:0]   ^ w_n2;
   assign w_rk   = {w_n0, w_n1, w_n2, w_n3};

   assign w_rnd  = w_mc ^ w_rk;
   assign w_fin  = w_sr ^ w_rk;

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         r_fsm   <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_state <= '0;
         r_key   <= '0;
         r_done  <= 1'b0;
         r_ct    <= '0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (iStAes) begin
                  r_state <= iPlainText ^ iAesKey;
                  r_key   <= iAesKey;
                  r_cnt   <= 4'd1;
                  r_fsm   <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               r_key <= w_rk;
               if (r_cnt == 4'd10) begin
                  r_state <= w_fin;
                  r_ct    <= w_fin;
                  r_done  <= 1'b1;
                  r_cnt   <= 4'd0;
                  r_fsm   <= ST_DONE;
               end else begin
                  r_state <= w_rnd;
                  r_cnt   <= r_cnt + 4'd1;
               end
            end
            ST_DONE: begin
               r_done <= 1'b0;
               r_fsm  <= ST_IDLE;
            end
            default: begin
               r_done <= 1'b0;
               r_fsm  <= ST_IDLE;
            end
         endcase
      end
   end

   assign oAesDone = r_done;
   assign oCpText  = r_ct;

endmodule

// File: tb/tb_aes_core.sv
// Directed bench for aes_core: FIPS-197 vectors, timing, input isolation, back-to-back and reset abort.
module tb_aes_core;

   logic         iClk = 1'b0;
   logic         iRsn = 1'b0;
   logic         iStAes = 1'b0;
   logic [127:0] iAesKey = '0;
   logic [127:0] iPlainText = '0;
   logic         oAesDone;
   logic [127:0] oCpText;

   aes_core dut (
      .iClk       (iClk),
      .iRsn       (iRsn),
      .iStAes     (iStAes),
      .iAesKey    (iAesKey),
      .iPlainText (iPlainText),
      .oAesDone   (oAesDone),
      .oCpText    (oCpText)
   );

   always #5 iClk = ~iClk;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] K_BB  = 128'h00112233445566778899aabbccddeeff;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   logic [7:0]   sb_tab [256];
   logic [127:0] pts [4];
   int           t_done [4];
   int           t_start;
   int           w;
   int           cnt;

   // Reference model: S-box derived from GF(2^8) inversion plus the affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv;
      inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  wk [44];
      logic [7:0]   st [16];
      logic [7:0]   t  [16];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) wk[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = wk[i-1];
         if (i % 4 == 0) begin
            tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         wk[i] = wk[i-4] ^ tmp;
      end
      for (int n = 0; n < 16; n++) st[n] = pt[127-8*n -: 8] ^ wk[n/4][31-8*(n%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int n = 0; n < 16; n++) st[n] = sb_tab[st[n]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = st[r+4*((c+r)%4)];
         for (int n = 0; n < 16; n++) st[n] = t[n];
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
               st[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
               st[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
               st[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
         end
         for (int n = 0; n < 16; n++) st[n] = st[n] ^ wk[4*rd + n/4][31-8*(n%4) -: 8];
      end
      for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n];
      return res;
   endfunction

   task automatic tick();
      @(posedge iClk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int limit, output int waited);
      waited = 0;
      while (oAesDone !== 1'b1 && waited < limit) begin
         tick();
         waited++;
      end
   endtask

   task automatic count_done(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (oAesDone === 1'b1) c++;
      end
   endtask

   task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp);
      int lat;
      iAesKey    = key;
      iPlainText = pt;
      iStAes     = 1'b1;
      tick();
      iStAes     = 1'b0;
      wait_done(30, lat);
      chk({tag, "_latency"}, 128'(lat), 128'd10);
      chk({tag, "_ct"}, oCpText, exp);
      tick();
      chk({tag, "_pulse_width"}, {127'd0, oAesDone}, 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

      tick();
      tick();
      chk("reset_done", {127'd0, oAesDone}, 128'd0);
      chk("reset_ct", oCpText, 128'd0);
      iRsn = 1'b1;
      tick();

      run_block("fips_c1", K_C1, P_C1, C_C1);
      run_block("fips_b", K_B, P_B, C_B);
      run_block("all_zero", 128'd0, 128'd0, C_Z);

      // Inputs and start pulses during ROUND must be ignored.
      iAesKey    = K_B;
      iPlainText = P_B;
      iStAes     = 1'b1;
      tick();
      iStAes     = 1'b0;
      tick();
      tick();
      iAesKey    = K_C1;
      iPlainText = P_C1;
      iStAes     = 1'b1;
      tick();
      iStAes     = 1'b0;
      iAesKey    = 128'hdeadbeef_01234567_89abcdef_fedcba98;
      wait_done(30, w);
      chk("iso_latency", 128'(w), 128'd7);
      chk("iso_ct", oCpText, C_B);
      count_done(15, cnt);
      chk("iso_no_extra_done", 128'(cnt), 128'd0);
      chk("iso_ct_hold", oCpText, C_B);

      // Back-to-back with iStAes held high.
      pts[0] = 128'h3a9f0c5e71b2d4488e06f1c3a5972b6d;
      pts[1] = 128'hc0ffee00123456789abcdef011223344;
      pts[2] = 128'h5555aaaa0f0ff0f0137f9ce2468ace01;
      pts[3] = 128'hfedcba9876543210ffffffff00000000;
      iAesKey    = K_BB;
      iPlainText = pts[0];
      iStAes     = 1'b1;
      tick();
      t_start = cyc;
      for (int i = 0; i < 4; i++) begin
         wait_done(30, w);
         t_done[i] = cyc;
         chk($sformatf("b2b_ct%0d", i), oCpText, aes_ref(K_BB, pts[i]));
         if (i == 0) chk("b2b_first_latency", 128'(t_done[0] - t_start), 128'd10);
         else chk($sformatf("b2b_spacing%0d", i), 128'(t_done[i] - t_done[i-1]), 128'd12);
         if (i < 3) iPlainText = pts[i+1];
         else iStAes = 1'b0;
         tick();
         chk($sformatf("b2b_done_low%0d", i), {127'd0, oAesDone}, 128'd0);
      end
      tick();
      tick();

      // Abort at round 5; no done pulse and ciphertext cleared.
      iAesKey    = K_C1;
      iPlainText = P_C1;
      iStAes     = 1'b1;
      tick();
      iStAes     = 1'b0;
      tick();
      tick();
      tick();
      tick();
      #2;
      iRsn = 1'b0;
      #1;
      chk("abort_done", {127'd0, oAesDone}, 128'd0);
      chk("abort_ct", oCpText, 128'd0);
      tick();
      iRsn = 1'b1;
      count_done(15, cnt);
      chk("abort_no_done", 128'(cnt), 128'd0);
      chk("abort_ct_hold", oCpText, 128'd0);
      run_block("after_abort", K_C1, P_C1, C_C1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
